led_blink_sequencer: RTL and testbench
======================================

# led_blink_sequencer

Drives a user-visible LED with counted blink codes, the output end of the push-button user interface. A request carries a blink count; the block plays that many ON/OFF pulses, holds a trailing dark gap so consecutive codes stay distinguishable, then accepts the next request. Upstream status logic, such as click and long-press handling or error reporting, feeds it through a valid/ready handshake. Its output pin goes straight to the board LED.

## Interface
- CLK_FREQUENCY, 100000000: clock frequency in Hz.
- LED_OUTPUT_LEVEL, 1: `led` value meaning "lit"; the dark level is the inverse.
- ON_MS, 200: duration of each lit pulse in ms.
- OFF_MS, 200: dark time between pulses of one code, in ms.
- GAP_MS, 1000: dark time after the last pulse of a code, in ms.
- CNT_WIDTH, 4: width of the blink count.
- One clock; reset is asynchronous and active-low.
- clk  in  1  system clock.
- reset_n  in  1  asynchronous active-low reset.
- req_valid  in  1  request present.
- req_count  in  CNT_WIDTH  number of blinks, unsigned.
- req_ready  out  1  block can accept a request.
- cancel  in  1  synchronous abort of the current code.
- busy  out  1  a code is playing, or its gap is running.
- led  out  1  LED drive.

## Operation
- Phase lengths in clocks:
  - ON_CLKS = CLK_FREQUENCY/1000*ON_MS
  - OFF_CLKS = CLK_FREQUENCY/1000*OFF_MS
  - GAP_CLKS = CLK_FREQUENCY/1000*GAP_MS
  - All three are computed as integers and must each be at least 1. Elaboration fails otherwise.
- The phase timer width is $clog2 of the largest of the three lengths, plus 1. The remaining-blinks counter is CNT_WIDTH bits.
- States: IDLE, ON, OFF, GAP.
- IDLE:
  - req_ready = ~cancel. `led` is dark and `busy` = 0.
  - When req_valid && req_ready and req_count != 0: capture the count, go to ON, load the timer.
  - A request with req_count == 0 is accepted and discarded. The block stays in IDLE with no LED activity.
- ON: `led` is lit. When the timer expires:
  - if remaining > 1, decrement remaining and go to OFF;
  - otherwise go to GAP.
- OFF: `led` is dark. Go to ON when the timer expires.
- GAP: `led` is dark. Go to IDLE when the timer expires.
- `req_ready` is 0 in every state except IDLE. `busy` = (state != IDLE).
- `cancel` asserted in any non-IDLE state forces IDLE on the next edge: `led` goes dark and the count is discarded, with no gap.
- If `cancel` and `req_valid` are both high in IDLE, cancel wins and the request is not accepted.
- The maximum count, 2^CNT_WIDTH-1, plays in full. The counter never wraps.
- All outputs are registered, except `req_ready`, which is combinational from the state and `cancel`.
- Reset values: state IDLE, `led` dark (~LED_OUTPUT_LEVEL), `busy` 0, timer 0, count 0. `req_ready` is 1 once reset is released.

## Timing
- A request accepted at edge E gives `led` lit in the E+1 cycle.
- Each ON lasts exactly ON_CLKS cycles, each OFF exactly OFF_CLKS, and the GAP exactly GAP_CLKS.
- Busy duration for count N = N*ON_CLKS + (N-1)*OFF_CLKS + GAP_CLKS cycles. `req_ready` rises in the cycle after the last GAP cycle.
- Reset asserted mid-code: `led` goes dark immediately (asynchronous). After release the block is in IDLE.
- `cancel` seen at edge E: `led` is dark from E+1, and `req_ready` is 1 from E+1 if `cancel` is low then.

## Structure
- Package led_blink_pkg holds:
  - the `state_t` enum {IDLE, ON, OFF, GAP};
  - a function returning the clocks per phase from frequency and ms.
- One natural sub-module, `phase_timer`: a loadable down-counter with a `done` flag. It is instantiated once and reloaded on each state entry.

## Test plan
All directed tests use CLK_FREQUENCY=1000, ON_MS=2, OFF_MS=3, GAP_MS=5.
- req_count=3 accepted at cycle 0 -> `led` lit in cycles 1-2, 6-7 and 11-12, dark elsewhere. `busy` is high in cycles 1-17. `req_ready` returns to 1 in cycle 18.
- req_count=0 -> accepted, `busy` stays 0, `led` never lit, `req_ready` stays 1.
- req_count=15 (max) -> exactly 15 pulses, busy for 15*2+14*3+5=77 cycles, no counter wrap.
- `cancel` pulsed in cycle 4 of a count=3 code -> `led` dark from cycle 5, `busy` 0 and `req_ready` 1 in cycle 5, no further pulses.
- `req_valid` and `cancel` both high in IDLE -> not accepted. The same request one cycle later without `cancel` -> accepted, `led` lit the next cycle.
- reset_n low during an ON phase -> `led` dark immediately. After release: IDLE, `busy` 0, `req_ready` 1.

Source files
------------

// File: rtl/led_blink_pkg.sv
// Shared types and helpers for the LED blink-code sequencer.
//   state_t      : sequencer states (IDLE, ON, OFF, GAP)
//   phase_clks() : clocks in one phase, from clock frequency (Hz) and length (ms)
//   max3()       : largest of three phase lengths, used to size the timer
package led_blink_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ON   = 2'd1,
    OFF  = 2'd2,
    GAP  = 2'd3
  } state_t;

  // Divide first so large frequencies do not overflow a 32-bit int.
  function automatic int phase_clks(input int freq_hz, input int ms);
    return (freq_hz / 1000) * ms;
  endfunction

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/led_blink_sequencer_phase_timer.sv
// Loadable down-counter timing one sequencer phase.
//   clk        : system clock
//   reset_n    : asynchronous active-low reset
//   load       : load load_value on this edge
//   load_value : phase length minus one
//   done       : counter is at zero (last cycle of the phase)
module phase_timer #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             load,
  input  logic [WIDTH-1:0] load_value,
  output logic             done
);

  logic [WIDTH-1:0] count;

  // Loading length-1 makes done fall on the final cycle of the phase,
  // so the sequencer can change state exactly at the phase boundary.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      count <= '0;
    end else if (load) begin
      count <= load_value;
    end else if (count != '0) begin
      count <= count - WIDTH'(1);
    end
  end

  assign done = (count == '0);

endmodule

// File: rtl/led_blink_sequencer.sv
// LED blink-code sequencer: plays req_count ON/OFF pulses followed by a
// dark gap, then accepts the next request.
//   clk       : system clock
//   reset_n   : asynchronous active-low reset
//   req_valid : request present
//   req_count : number of blinks (0 is accepted and discarded)
//   req_ready : combinational, high in IDLE while cancel is low
//   cancel    : synchronous abort of the current code
//   busy      : registered, a code or its gap is in progress
//   led       : registered LED drive, LED_OUTPUT_LEVEL means lit
module led_blink_sequencer
  import led_blink_pkg::*;
#(
  parameter int CLK_FREQUENCY    = 100000000,
  parameter bit LED_OUTPUT_LEVEL = 1'b1,
  parameter int ON_MS            = 200,
  parameter int OFF_MS           = 200,
  parameter int GAP_MS           = 1000,
  parameter int CNT_WIDTH        = 4
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 req_valid,
  input  logic [CNT_WIDTH-1:0] req_count,
  output logic                 req_ready,
  input  logic                 cancel,
  output logic                 busy,
  output logic                 led
);

  localparam int ON_CLKS  = phase_clks(CLK_FREQUENCY, ON_MS);
  localparam int OFF_CLKS = phase_clks(CLK_FREQUENCY, OFF_MS);
  localparam int GAP_CLKS = phase_clks(CLK_FREQUENCY, GAP_MS);
  localparam int MAX_CLKS = max3(ON_CLKS, OFF_CLKS, GAP_CLKS);
  localparam int TMR_W    = $clog2(MAX_CLKS) + 1;

  localparam logic [TMR_W-1:0] ON_LOAD  = TMR_W'(ON_CLKS - 1);
  localparam logic [TMR_W-1:0] OFF_LOAD = TMR_W'(OFF_CLKS - 1);
  localparam logic [TMR_W-1:0] GAP_LOAD = TMR_W'(GAP_CLKS - 1);

  localparam logic LED_LIT  = LED_OUTPUT_LEVEL;
  localparam logic LED_DARK = ~LED_OUTPUT_LEVEL;

  // A zero-length phase would make the sequencer skip states.
  if (ON_CLKS < 1 || OFF_CLKS < 1 || GAP_CLKS < 1) begin : g_bad_timing
    $error("led_blink_sequencer: every phase must last at least one clock");
  end

  state_t               state;
  logic [CNT_WIDTH-1:0] remaining;
  logic                 tmr_load;
  logic [TMR_W-1:0]     tmr_value;
  logic                 tmr_done;

  assign req_ready = (state == IDLE) && !cancel;

  // Timer reload on every phase entry; cancel suppresses it since the
  // sequencer returns to IDLE instead.
  always_comb begin
    tmr_load  = 1'b0;
    tmr_value = '0;
    unique case (state)
      IDLE: begin
        if (req_valid && req_ready && req_count != '0) begin
          tmr_load  = 1'b1;
          tmr_value = ON_LOAD;
        end
      end
      ON: begin
        if (!cancel && tmr_done) begin
          tmr_load  = 1'b1;
          tmr_value = (remaining > CNT_WIDTH'(1)) ? OFF_LOAD : GAP_LOAD;
        end
      end
      OFF: begin
        if (!cancel && tmr_done) begin
          tmr_load  = 1'b1;
          tmr_value = ON_LOAD;
        end
      end
      default: begin
      end
    endcase
  end

  phase_timer #(
    .WIDTH(TMR_W)
  ) u_phase_timer (
    .clk       (clk),
    .reset_n   (reset_n),
    .load      (tmr_load),
    .load_value(tmr_value),
    .done      (tmr_done)
  );

  // remaining counts pulses still to light, including the current one, so
  // the last pulse is recognised at remaining == 1 and it never wraps.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= IDLE;
      led       <= LED_DARK;
      busy      <= 1'b0;
      remaining <= '0;
    end else if (cancel && state != IDLE) begin
      state     <= IDLE;
      led       <= LED_DARK;
      busy      <= 1'b0;
      remaining <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (req_valid && req_ready && req_count != '0) begin
            state     <= ON;
            led       <= LED_LIT;
            busy      <= 1'b1;
            remaining <= req_count;
          end
        end
        ON: begin
          if (tmr_done) begin
            led <= LED_DARK;
            if (remaining > CNT_WIDTH'(1)) begin
              remaining <= remaining - CNT_WIDTH'(1);
              state     <= OFF;
            end else begin
              state <= GAP;
            end
          end
        end
        OFF: begin
          if (tmr_done) begin
            state <= ON;
            led   <= LED_LIT;
          end
        end
        GAP: begin
          if (tmr_done) begin
            state     <= IDLE;
            busy      <= 1'b0;
            remaining <= '0;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_led_blink_sequencer.sv
// Testbench for led_blink_sequencer: directed scenarios plus random traffic,
// checked cycle by cycle against a timeline model through a scoreboard queue.
module tb_led_blink_sequencer;

  localparam int FREQ   = 1000;
  localparam int ON_C   = FREQ / 1000 * 2;
  localparam int OFF_C  = FREQ / 1000 * 3;
  localparam int GAP_C  = FREQ / 1000 * 5;
  localparam int CW     = 4;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic          req_valid = 1'b0;
  logic [CW-1:0] req_count = '0;
  logic          cancel = 1'b0;
  logic          req_ready;
  logic          busy;
  logic          led;

  typedef struct packed {
    logic led;
    logic busy;
  } exp_t;

  exp_t exp_q[$];
  bit   plan[$];     // expected LED level for each remaining cycle of a code
  int   errors = 0;
  int   checks = 0;

  led_blink_sequencer #(
    .CLK_FREQUENCY   (FREQ),
    .LED_OUTPUT_LEVEL(1'b1),
    .ON_MS           (2),
    .OFF_MS          (3),
    .GAP_MS          (5),
    .CNT_WIDTH       (CW)
  ) dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .req_valid(req_valid),
    .req_count(req_count),
    .req_ready(req_ready),
    .cancel   (cancel),
    .busy     (busy),
    .led      (led)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
    end
  endtask

  // Reference model, evaluated at each rising edge from the inputs as they
  // stood before it. A code is a flat timeline of lit/dark cycles.
  task automatic model_edge();
    exp_t e;
    if (!reset_n) begin
      plan.delete();
    end else if (plan.size() != 0) begin
      if (cancel) plan.delete();
      else void'(plan.pop_front());
    end else if (req_valid && !cancel && req_count != 0) begin
      for (int i = 1; i <= int'(req_count); i++) begin
        for (int k = 0; k < ON_C; k++) plan.push_back(1'b1);
        if (i < int'(req_count))
          for (int k = 0; k < OFF_C; k++) plan.push_back(1'b0);
      end
      for (int k = 0; k < GAP_C; k++) plan.push_back(1'b0);
    end
    e.busy = (plan.size() != 0);
    e.led  = e.busy ? plan[0] : 1'b0;
    exp_q.push_back(e);
  endtask

  task automatic step(input logic v, input logic [CW-1:0] n, input logic c);
    req_valid = v;
    req_count = n;
    cancel    = c;
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic idle(input int cycles);
    for (int i = 0; i < cycles; i++) step(1'b0, '0, 1'b0);
  endtask

  // Monitor: compares every cycle's outputs against the queued expectation.
  always @(negedge clk) begin
    exp_t e;
    if (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      check("led", int'(led), int'(e.led));
      check("busy", int'(busy), int'(e.busy));
      check("req_ready", int'(req_ready), int'(!e.busy && !cancel));
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    int busy_cycles;
    int pulses;
    logic prev_led;

    // Reset held for a few edges, then released.
    idle(3);
    reset_n = 1'b1;
    idle(2);

    // Three-blink code, then idle past its gap.
    step(1'b1, 4'd3, 1'b0);
    idle(20);

    // Zero-count request: accepted, nothing happens.
    step(1'b1, 4'd0, 1'b0);
    idle(4);

    // Cancel during the first OFF phase of a three-blink code.
    step(1'b1, 4'd3, 1'b0);
    idle(3);
    step(1'b0, '0, 1'b1);
    idle(6);

    // Cancel beats a simultaneous request; the retry is accepted.
    step(1'b1, 4'd5, 1'b1);
    step(1'b1, 4'd5, 1'b0);
    check("lit_after_retry", int'(led), 1);
    idle(30);

    // Maximum count plays every pulse without wrapping.
    step(1'b1, 4'd15, 1'b0);
    busy_cycles = 0;
    pulses      = 0;
    prev_led    = 1'b0;
    for (int i = 0; i < 90; i++) begin
      if (busy) busy_cycles++;
      if (led && !prev_led) pulses++;
      prev_led = led;
      step(1'b0, '0, 1'b0);
    end
    check("max_busy_cycles", busy_cycles, 15 * ON_C + 14 * OFF_C + GAP_C);
    check("max_pulses", pulses, 15);

    // Reset asserted during an ON phase darkens the LED without a clock.
    step(1'b1, 4'd2, 1'b0);
    idle(1);
    @(negedge clk);
    #1;
    reset_n = 1'b0;
    #1;
    check("async_reset_led", int'(led), 0);
    check("async_reset_busy", int'(busy), 0);
    idle(2);
    reset_n = 1'b1;
    idle(3);

    // Random requests and occasional cancels.
    for (int i = 0; i < 1500; i++) begin
      step(($urandom % 3) == 0, CW'($urandom % 16), ($urandom % 25) == 0);
    end
    idle(3);

    @(negedge clk);
    #1;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
